// File: rtl/datapath_pkg.sv
// Shared definitions for the single-bus mini-RISC datapath.
// Bus source order and ALU op encodings live here.
package datapath_pkg;

    localparam int DATA_W = 32;
    localparam int C_W    = 19;

    // Listed in bus priority order, highest first.
    typedef enum logic [3:0] {
        SRC_NONE,
        SRC_PC,
        SRC_MDR,
        SRC_ZLO,
        SRC_ZHI,
        SRC_R2,
        SRC_R3,
        SRC_HI,
        SRC_LO,
        SRC_INPORT,
        SRC_C
    } bus_src_e;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_AND,
        OP_OR,
        OP_NEG,
        OP_INC
    } alu_op_e;

endpackage

// File: rtl/alu.sv
// Combinational ALU: A comes from Y, B from the bus.
// All results wrap modulo 2^W.
module alu
    import datapath_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  alu_op_e      op,
    output logic [W-1:0] y
);

    always_comb begin
        y = a + b;
        unique case (op)
            OP_INC:  y = b + W'(1);
            OP_NEG:  y = '0 - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            default: y = a + b;
        endcase
    end

endmodule

// File: rtl/reg32.sv
// Register cell with asynchronous active-low clear and load enable.
// Reused for every datapath register.
module reg32 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q <= '0;
        end else if (ld) begin
            q <= d;
        end
    end

endmodule

// File: rtl/datapath.sv
// Single-bus 32-bit datapath: registers, bus mux, MDR mux and ALU.
// Sequenced externally through one-hot out/in strobes.
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] MDatain,
    input  logic [WIDTH-1:0] InPort,
    input  logic             Read,
    input  logic             PCout,
    input  logic             Zlowout,
    input  logic             Zhighout,
    input  logic             MDRout,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             LOout,
    input  logic             HIout,
    input  logic             InPortout,
    input  logic             Cout,
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             IncPC,
    input  logic             AND,
    input  logic             OR,
    input  logic             NEG,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] R1_q,
    output logic [WIDTH-1:0] PC_q,
    output logic [WIDTH-1:0] IR_q,
    output logic [WIDTH-1:0] MAR_q
);

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] r2;
    logic [WIDTH-1:0] r3;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] zlo;
    logic [WIDTH-1:0] zhi;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mdr;
    logic [WIDTH-1:0] mdr_d;
    logic [WIDTH-1:0] alu_y;
    logic [WIDTH-1:0] c_val;
    bus_src_e         src;
    alu_op_e          op;

    // First asserted strobe owns the bus.
    always_comb begin
        src = SRC_NONE;
        if (PCout) begin
            src = SRC_PC;
        end else if (MDRout) begin
            src = SRC_MDR;
        end else if (Zlowout) begin
            src = SRC_ZLO;
        end else if (Zhighout) begin
            src = SRC_ZHI;
        end else if (R2out) begin
            src = SRC_R2;
        end else if (R3out) begin
            src = SRC_R3;
        end else if (HIout) begin
            src = SRC_HI;
        end else if (LOout) begin
            src = SRC_LO;
        end else if (InPortout) begin
            src = SRC_INPORT;
        end else if (Cout) begin
            src = SRC_C;
        end
    end

    assign c_val = {{(WIDTH-C_W){IR_q[C_W-1]}}, IR_q[C_W-1:0]};

    always_comb begin
        bus = '0;
        unique case (src)
            SRC_PC:     bus = PC_q;
            SRC_MDR:    bus = mdr;
            SRC_ZLO:    bus = zlo;
            SRC_ZHI:    bus = zhi;
            SRC_R2:     bus = r2;
            SRC_R3:     bus = r3;
            SRC_HI:     bus = hi;
            SRC_LO:     bus = lo;
            SRC_INPORT: bus = InPort;
            SRC_C:      bus = c_val;
            default:    bus = '0;
        endcase
    end

    assign BusMuxOut = bus;

    always_comb begin
        op = OP_ADD;
        if (IncPC) begin
            op = OP_INC;
        end else if (NEG) begin
            op = OP_NEG;
        end else if (AND) begin
            op = OP_AND;
        end else if (OR) begin
            op = OP_OR;
        end
    end

    alu #(.W(WIDTH)) u_alu (
        .a  (y),
        .b  (bus),
        .op (op),
        .y  (alu_y)
    );

    assign mdr_d = Read ? MDatain : bus;

    reg32 #(.W(WIDTH)) u_r1 (
        .clk(clk), .clr(clr), .ld(R1in),
        .d(bus), .q(R1_q)
    );

    reg32 #(.W(WIDTH)) u_r2 (
        .clk(clk), .clr(clr), .ld(R2in),
        .d(bus), .q(r2)
    );

    reg32 #(.W(WIDTH)) u_r3 (
        .clk(clk), .clr(clr), .ld(R3in),
        .d(bus), .q(r3)
    );

    reg32 #(.W(WIDTH)) u_pc (
        .clk(clk), .clr(clr), .ld(PCin),
        .d(bus), .q(PC_q)
    );

    reg32 #(.W(WIDTH)) u_ir (
        .clk(clk), .clr(clr), .ld(IRin),
        .d(bus), .q(IR_q)
    );

    reg32 #(.W(WIDTH)) u_y (
        .clk(clk), .clr(clr), .ld(Yin),
        .d(bus), .q(y)
    );

    reg32 #(.W(WIDTH)) u_mar (
        .clk(clk), .clr(clr), .ld(MARin),
        .d(bus), .q(MAR_q)
    );

    reg32 #(.W(WIDTH)) u_mdr (
        .clk(clk), .clr(clr), .ld(MDRin),
        .d(mdr_d), .q(mdr)
    );

    reg32 #(.W(WIDTH)) u_zlo (
        .clk(clk), .clr(clr), .ld(Zin),
        .d(alu_y), .q(zlo)
    );

    // Only single-width ops exist, so Z's upper half always loads zero.
    reg32 #(.W(WIDTH)) u_zhi (
        .clk(clk), .clr(clr), .ld(Zin),
        .d('0), .q(zhi)
    );

    reg32 #(.W(WIDTH)) u_hi (
        .clk(clk), .clr(clr), .ld(1'b0),
        .d('0), .q(hi)
    );

    reg32 #(.W(WIDTH)) u_lo (
        .clk(clk), .clr(clr), .ld(1'b0),
        .d('0), .q(lo)
    );

endmodule

// File: tb/tb_datapath.sv
// Scoreboard bench for datapath: directed micro-steps then random ones,
// compared against a behavioural register-file model.
module tb_datapath;

    localparam logic [23:0] PCOUT  = 24'h000001;
    localparam logic [23:0] MDROUT = 24'h000002;
    localparam logic [23:0] ZLOOUT = 24'h000004;
    localparam logic [23:0] ZHIOUT = 24'h000008;
    localparam logic [23:0] R2OUT  = 24'h000010;
    localparam logic [23:0] R3OUT  = 24'h000020;
    localparam logic [23:0] HIOUT  = 24'h000040;
    localparam logic [23:0] LOOUT  = 24'h000080;
    localparam logic [23:0] INOUT  = 24'h000100;
    localparam logic [23:0] COUT   = 24'h000200;
    localparam logic [23:0] MARIN  = 24'h000400;
    localparam logic [23:0] ZIN    = 24'h000800;
    localparam logic [23:0] PCIN   = 24'h001000;
    localparam logic [23:0] MDRIN  = 24'h002000;
    localparam logic [23:0] IRIN   = 24'h004000;
    localparam logic [23:0] YIN    = 24'h008000;
    localparam logic [23:0] R1IN   = 24'h010000;
    localparam logic [23:0] R2IN   = 24'h020000;
    localparam logic [23:0] R3IN   = 24'h040000;
    localparam logic [23:0] INCPC  = 24'h080000;
    localparam logic [23:0] NEGS   = 24'h100000;
    localparam logic [23:0] ANDS   = 24'h200000;
    localparam logic [23:0] ORS    = 24'h400000;
    localparam logic [23:0] READ   = 24'h800000;

    logic        clk = 1'b0;
    logic        clr;
    logic [23:0] ctl;
    logic [31:0] MDatain;
    logic [31:0] InPort;
    logic [31:0] bus;
    logic [31:0] r1;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mar;

    always #5 clk = ~clk;

    datapath dut (
        .clk(clk), .clr(clr),
        .MDatain(MDatain), .InPort(InPort), .Read(ctl[23]),
        .PCout(ctl[0]), .Zlowout(ctl[2]), .Zhighout(ctl[3]),
        .MDRout(ctl[1]), .R2out(ctl[4]), .R3out(ctl[5]),
        .LOout(ctl[7]), .HIout(ctl[6]), .InPortout(ctl[8]),
        .Cout(ctl[9]),
        .MARin(ctl[10]), .Zin(ctl[11]), .PCin(ctl[12]),
        .MDRin(ctl[13]), .IRin(ctl[14]), .Yin(ctl[15]),
        .R1in(ctl[16]), .R2in(ctl[17]), .R3in(ctl[18]),
        .IncPC(ctl[19]), .AND(ctl[21]), .OR(ctl[22]), .NEG(ctl[20]),
        .BusMuxOut(bus), .R1_q(r1), .PC_q(pc), .IR_q(ir), .MAR_q(mar)
    );

    typedef struct {
        logic [31:0] bus;
        logic [31:0] r1;
        logic [31:0] pc;
        logic [31:0] ir;
        logic [31:0] mar;
        string       tag;
    } exp_t;

    exp_t q[$];
    int passed = 0;
    int total  = 0;

    logic [31:0] m_r1, m_r2, m_r3, m_pc, m_ir, m_y, m_mar, m_mdr;
    logic [63:0] m_z;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act === want) passed++;
        else $display("FAIL %s: got %h required %h", name, act, want);
    endtask

    task automatic model_reset();
        m_r1 = 0; m_r2 = 0; m_r3 = 0; m_pc = 0;
        m_ir = 0; m_y = 0; m_mar = 0; m_mdr = 0; m_z = 0;
    endtask

    function automatic logic [31:0] m_bus(input logic [23:0] c,
                                          input logic [31:0] inp);
        logic [31:0] src [10];
        src[0] = m_pc;
        src[1] = m_mdr;
        src[2] = m_z[31:0];
        src[3] = m_z[63:32];
        src[4] = m_r2;
        src[5] = m_r3;
        src[6] = 32'h0;
        src[7] = 32'h0;
        src[8] = inp;
        src[9] = {{13{m_ir[18]}}, m_ir[18:0]};
        for (int i = 0; i < 10; i++)
            if (c[i]) return src[i];
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_alu(input logic [23:0] c,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        if (c[19]) return b + 1;
        if (c[20]) return 32'h0 - b;
        if (c[21]) return a & b;
        if (c[22]) return a | b;
        return a + b;
    endfunction

    task automatic step(input logic [23:0] c, input logic [31:0] md,
                        input string tag);
        logic [31:0] b, r;
        exp_t e;
        @(negedge clk);
        ctl = c;
        MDatain = md;
        InPort = $urandom;
        b = m_bus(c, InPort);
        r = m_alu(c, m_y, b);
        if (c[10]) m_mar = b;
        if (c[11]) m_z = {32'h0, r};
        if (c[12]) m_pc = b;
        if (c[13]) m_mdr = c[23] ? md : b;
        if (c[14]) m_ir = b;
        if (c[15]) m_y = b;
        if (c[16]) m_r1 = b;
        if (c[17]) m_r2 = b;
        if (c[18]) m_r3 = b;
        e.bus = b; e.r1 = m_r1; e.pc = m_pc;
        e.ir = m_ir; e.mar = m_mar; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check({e.tag, "_bus"}, bus, e.bus);
                @(posedge clk);
                #1;
                check({e.tag, "_r1"}, r1, e.r1);
                check({e.tag, "_pc"}, pc, e.pc);
                check({e.tag, "_ir"}, ir, e.ir);
                check({e.tag, "_mar"}, mar, e.mar);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] c;
        clr = 1'b0;
        ctl = '0;
        MDatain = '0;
        InPort = '0;
        model_reset();
        #12;
        check("rst_bus", bus, 32'h0);
        check("rst_r1", r1, 32'h0);
        check("rst_pc", pc, 32'h0);
        check("rst_ir", ir, 32'h0);
        check("rst_mar", mar, 32'h0);
        #1 clr = 1'b1;

        step(MDRIN | READ, 32'h12, "ld_mdr12");
        step(MDROUT | R2IN, 0, "ld_r2");
        step(MDRIN | READ, 32'h14, "ld_mdr14");
        step(MDROUT | R3IN, 0, "ld_r3");
        step(MDRIN | READ, 32'h18, "ld_mdr18");
        step(MDROUT | R1IN, 0, "ld_r1");
        settle();
        check("r1_const", r1, 32'h18);

        step(PCOUT | MARIN | INCPC | ZIN, 0, "f0");
        step(ZLOOUT | PCIN | READ | MDRIN, 32'h28918000, "f1");
        step(MDROUT | IRIN, 0, "f2");
        settle();
        check("fetch_pc", pc, 32'h1);
        check("fetch_ir", ir, 32'h28918000);

        step(R2OUT | YIN, 0, "neg0");
        step(R3OUT | NEGS | ZIN, 0, "neg1");
        step(ZLOOUT | R1IN, 0, "neg2");
        step(ZHIOUT, 0, "zhi");
        settle();
        check("neg_r1", r1, 32'hFFFFFFEC);
        check("zhi_bus", bus, 32'h0);

        step(R3OUT | ANDS | ZIN, 0, "and1");
        step(ZLOOUT | R1IN, 0, "and2");
        settle();
        check("and_r1", r1, 32'h10);
        step(R3OUT | ORS | ZIN, 0, "or1");
        step(ZLOOUT | R1IN, 0, "or2");
        settle();
        check("or_r1", r1, 32'h16);
        step(R3OUT | ZIN, 0, "add1");
        step(ZLOOUT | R1IN, 0, "add2");
        settle();
        check("add_r1", r1, 32'h26);

        step(MDRIN | READ, 32'h0007FFFF, "c0");
        step(MDROUT | IRIN, 0, "c1");
        step(COUT, 0, "cout");
        step(24'h0, 0, "nostrobe");
        step(PCOUT | R2OUT, 0, "prio");
        step(PCOUT | PCIN, 0, "selfload");

        step(MDRIN | READ, 32'hFFFFFFFF, "w0");
        step(MDROUT | INCPC | ZIN, 0, "w1");
        step(ZLOOUT | PCIN, 0, "w2");
        settle();
        check("inc_wrap", pc, 32'h0);
        step(MDRIN | READ, 32'h80000000, "n0");
        step(MDROUT | NEGS | ZIN, 0, "n1");
        step(ZLOOUT | R1IN, 0, "n2");
        settle();
        check("neg_min", r1, 32'h80000000);

        @(negedge clk);
        ctl = '0;
        #2 clr = 1'b0;
        #1;
        check("arst_bus", bus, 32'h0);
        check("arst_r1", r1, 32'h0);
        check("arst_pc", pc, 32'h0);
        check("arst_ir", ir, 32'h0);
        check("arst_mar", mar, 32'h0);
        #1 clr = 1'b1;
        model_reset();

        for (int i = 0; i < 400; i++) begin
            c = 24'($urandom);
            c[9:0] = c[9:0] & 10'($urandom) & 10'($urandom);
            c[22:19] = c[22:19] & 4'($urandom);
            step(c, $urandom, "rnd");
        end

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
